// File: rtl/cpu_defs.sv
// Shared definitions for the instruction fetch slice: reset vector,
// NOP encoding, fetch FSM state encoding and small address helpers.
package cpu_defs;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES      = 32'd4;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

   // Next sequential instruction address; wraps modulo 2^32.
   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + INSTR_BYTES;
   endfunction

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   // True when a target address is not word aligned.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction and its PC+4.
// flush kills the valid bit but keeps the payload; hold is implicit when
// neither load nor flush is asserted.
module if_id_reg
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc4_in,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc4,
   output logic        if_valid
);

   logic [31:0] instr_reg;
   logic [31:0] instr_next;
   logic [31:0] pc4_reg;
   logic [31:0] pc4_next;
   logic        valid_reg;
   logic        valid_next;

   // Select load / flush / hold for the register contents; flush wins.
   always_comb begin
      instr_next = instr_reg;
      pc4_next   = pc4_reg;
      valid_next = valid_reg;
      if (flush) begin
         valid_next = 1'b0;
      end else if (load) begin
         instr_next = instr_in;
         pc4_next   = pc4_in;
         valid_next = 1'b1;
      end
   end

   // Register update with synchronous reset to a NOP bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_reg <= NOP_INSTR;
         pc4_reg   <= 32'h0000_0000;
         valid_reg <= 1'b0;
      end else begin
         instr_reg <= instr_next;
         pc4_reg   <= pc4_next;
         valid_reg <= valid_next;
      end
   end

   assign if_instr = instr_reg;
   assign if_pc4   = pc4_reg;
   assign if_valid = valid_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, a BOOT/RUN sequencer, the fetch
// counter and the sticky misaligned-redirect flag, and feeds the IF/ID
// register. imem_addr comes straight from the PC register.
module fetch_unit
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc4,
   output logic        if_valid,
   output logic        misalign,
   output logic [31:0] fetch_count
);

   fetch_state_t state_reg;
   fetch_state_t state_next;

   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic [31:0] count_reg;
   logic [31:0] count_next;
   logic        misalign_reg;
   logic        misalign_next;

   logic        ifid_load;
   logic        ifid_flush;
   logic [31:0] seq_pc;

   assign seq_pc = pc_plus4(pc_reg);

   // State register: BOOT after reset, RUN thereafter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= BOOT;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: BOOT lasts exactly one cycle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         BOOT:    state_next = RUN;
         RUN:     state_next = RUN;
         default: state_next = BOOT;
      endcase
   end

   // Output/datapath control: redirect beats stall, stall beats fetch.
   always_comb begin
      pc_next       = pc_reg;
      count_next    = count_reg;
      misalign_next = misalign_reg;
      ifid_load     = 1'b0;
      ifid_flush    = 1'b0;
      case (state_reg)
         BOOT: begin
            // Redirects are ignored here; keep the IF/ID slot empty.
            ifid_flush = 1'b1;
         end
         RUN: begin
            if (redirect) begin
               pc_next    = word_align(redirect_pc);
               ifid_flush = 1'b1;
               if (is_misaligned(redirect_pc)) begin
                  misalign_next = 1'b1;
               end
            end else if (!stall) begin
               pc_next    = seq_pc;
               count_next = count_reg + 32'd1;
               ifid_load  = 1'b1;
            end
         end
         default: begin
            ifid_flush = 1'b1;
         end
      endcase
   end

   // PC, fetch counter and sticky misalign flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg       <= RESET_PC;
         count_reg    <= 32'h0000_0000;
         misalign_reg <= 1'b0;
      end else begin
         pc_reg       <= pc_next;
         count_reg    <= count_next;
         misalign_reg <= misalign_next;
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (ifid_load),
      .flush    (ifid_flush),
      .instr_in (imem_instr),
      .pc4_in   (seq_pc),
      .if_instr (if_instr),
      .if_pc4   (if_pc4),
      .if_valid (if_valid)
   );

   assign imem_addr   = pc_reg;
   assign misalign    = misalign_reg;
   assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Instruction memory returns addr|0xA000.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] if_instr;
   logic [31:0] if_pc4;
   logic        if_valid;
   logic        misalign;
   logic [31:0] fetch_count;

   int checks;
   int failures;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .if_instr    (if_instr),
      .if_pc4      (if_pc4),
      .if_valid    (if_valid),
      .misalign    (misalign),
      .fetch_count (fetch_count)
   );

   assign imem_instr = imem_addr | 32'h0000_A000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      step(); step();
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
      checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
      checks++; if (if_pc4 !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=0", if_pc4); end
      checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
      checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
      $display("reset: addr=%h valid=%b count=%0d", imem_addr, if_valid, fetch_count);
      rst = 1'b0;
   endtask

   // Boot cycle with a misaligned redirect offered: must be ignored.
   task automatic test_boot();
      redirect = 1'b1; redirect_pc = 32'h0000_0081;
      step();
      redirect = 1'b0; redirect_pc = 32'h0;
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL boot_addr got=%h exp=0", imem_addr); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", if_valid); end
      checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL boot_misalign got=%b exp=0", misalign); end
      checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL boot_count got=%0d exp=0", fetch_count); end
      $display("boot: addr=%h valid=%b misalign=%b", imem_addr, if_valid, misalign);
   endtask

   task automatic test_fetch();
      logic [31:0] exp_instr [3] = '{32'hA000, 32'hA004, 32'hA008};
      logic [31:0] exp_pc4   [3] = '{32'h4, 32'h8, 32'hC};
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (if_instr !== exp_instr[i]) begin failures++; $display("FAIL fetch_instr[%0d] got=%h exp=%h", i, if_instr, exp_instr[i]); end
         checks++; if (if_pc4 !== exp_pc4[i]) begin failures++; $display("FAIL fetch_pc4[%0d] got=%h exp=%h", i, if_pc4, exp_pc4[i]); end
         checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL fetch_valid[%0d] got=%b exp=1", i, if_valid); end
         checks++; if (fetch_count !== 32'(i + 1)) begin failures++; $display("FAIL fetch_count[%0d] got=%0d exp=%0d", i, fetch_count, i + 1); end
         checks++; if (imem_addr !== exp_pc4[i]) begin failures++; $display("FAIL fetch_addr[%0d] got=%h exp=%h", i, imem_addr, exp_pc4[i]); end
         $display("fetch %0d: instr=%h pc4=%h count=%0d", i, if_instr, if_pc4, fetch_count);
      end
   endtask

   // Redirect back to 0x8, stall two cycles there, then release.
   task automatic test_stall();
      redirect = 1'b1; redirect_pc = 32'h8;
      step();
      redirect = 1'b0; stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=8", i, imem_addr); end
         checks++; if (if_instr !== 32'hA008) begin failures++; $display("FAIL stall_instr[%0d] got=%h exp=a008", i, if_instr); end
         checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL stall_count[%0d] got=%0d exp=3", i, fetch_count); end
         checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=0", i, if_valid); end
         $display("stall %0d: addr=%h count=%0d", i, imem_addr, fetch_count);
      end
      stall = 1'b0;
      step();
      checks++; if (imem_addr !== 32'hC) begin failures++; $display("FAIL release_addr got=%h exp=c", imem_addr); end
      checks++; if (if_instr !== 32'hA008) begin failures++; $display("FAIL release_instr got=%h exp=a008", if_instr); end
      checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL release_count got=%0d exp=4", fetch_count); end
      checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL release_valid got=%b exp=1", if_valid); end
      $display("release: addr=%h instr=%h count=%0d", imem_addr, if_instr, fetch_count);
   endtask

   // Redirect and stall together: redirect must win.
   task automatic test_redirect_stall();
      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
      step();
      redirect = 1'b0; stall = 1'b0;
      checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL rdst_addr got=%h exp=40", imem_addr); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rdst_valid got=%b exp=0", if_valid); end
      checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL rdst_count got=%0d exp=4", fetch_count); end
      checks++; if (if_instr !== 32'hA008) begin failures++; $display("FAIL rdst_instr got=%h exp=a008", if_instr); end
      step();
      checks++; if (if_pc4 !== 32'h44) begin failures++; $display("FAIL rdst_pc4 got=%h exp=44", if_pc4); end
      checks++; if (if_instr !== 32'hA040) begin failures++; $display("FAIL rdst_instr2 got=%h exp=a040", if_instr); end
      checks++; if (fetch_count !== 32'd5) begin failures++; $display("FAIL rdst_count2 got=%0d exp=5", fetch_count); end
      $display("redirect+stall: addr=%h pc4=%h count=%0d", imem_addr, if_pc4, fetch_count);
   endtask

   task automatic test_misalign();
      redirect = 1'b1; redirect_pc = 32'h43;
      step();
      checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL mis_addr got=%h exp=40", imem_addr); end
      checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL mis_set got=%b exp=1", misalign); end
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0; redirect_pc = 32'h0;
      checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL mis_addr2 got=%h exp=100", imem_addr); end
      checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL mis_sticky got=%b exp=1", misalign); end
      step();
      checks++; if (if_instr !== 32'hA100) begin failures++; $display("FAIL mis_instr got=%h exp=a100", if_instr); end
      checks++; if (fetch_count !== 32'd6) begin failures++; $display("FAIL mis_count got=%0d exp=6", fetch_count); end
      checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL mis_sticky2 got=%b exp=1", misalign); end
      $display("misalign: addr=%h misalign=%b count=%0d", imem_addr, misalign, fetch_count);
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", imem_addr); end
      step();
      checks++; if (if_pc4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=0", if_pc4); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr1 got=%h exp=0", imem_addr); end
      checks++; if (if_instr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_instr got=%h exp=fffffffc", if_instr); end
      step();
      checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL wrap_addr2 got=%h exp=4", imem_addr); end
      checks++; if (if_pc4 !== 32'h4) begin failures++; $display("FAIL wrap_pc4b got=%h exp=4", if_pc4); end
      checks++; if (fetch_count !== 32'd8) begin failures++; $display("FAIL wrap_count got=%0d exp=8", fetch_count); end
      $display("wrap: addr=%h pc4=%h count=%0d", imem_addr, if_pc4, fetch_count);
   endtask

   // Reset asserted during a stall at 0x20, then during a misaligned redirect.
   task automatic test_reset_mid();
      redirect = 1'b1; redirect_pc = 32'h20;
      step();
      redirect = 1'b0; stall = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0; stall = 1'b0;
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rmid_addr got=%h exp=0", imem_addr); end
      checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", if_valid); end
      checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rmid_instr got=%h exp=0", if_instr); end
      checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", fetch_count); end
      checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL rmid_misalign got=%b exp=0", misalign); end
      // BOOT cycle: no fetch yet.
      step();
      checks++; if (if_valid !== 1'b0 || fetch_count !== 32'h0) begin failures++; $display("FAIL rmid_boot got=%b/%0d exp=0/0", if_valid, fetch_count); end
      step();
      checks++; if (if_instr !== 32'hA000 || fetch_count !== 32'd1) begin failures++; $display("FAIL rmid_first got=%h/%0d exp=a000/1", if_instr, fetch_count); end
      // Reset beats a misaligned redirect.
      redirect = 1'b1; redirect_pc = 32'h43; rst = 1'b1;
      step();
      rst = 1'b0; redirect = 1'b0;
      checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL rrd_misalign got=%b exp=0", misalign); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rrd_addr got=%h exp=0", imem_addr); end
      $display("reset mid-op: addr=%h valid=%b count=%0d", imem_addr, if_valid, fetch_count);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_boot();
      test_fetch();
      test_stall();
      test_redirect_stall();
      test_misalign();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetched instruction.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 stall  input  1  hold PC and IF/ID register this cycle.
REQ-005 redirect  input  1  taken branch/jump; load redirect_pc.
REQ-006 redirect_pc  input  32  branch/jump target byte address.
REQ-007 imem_addr  output  32  byte address to instruction memory; equals PC.
REQ-008 imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-009 if_instr  output  32  IF/ID instruction register.
REQ-010 if_pc4  output  32  PC+4 of the instruction held in if_instr.
REQ-011 if_valid  output  1  if_instr holds a real fetched instruction.
REQ-012 misalign  output  1  sticky flag: a redirect target had nonzero bits [1:0].
REQ-013 fetch_count  output  32  number of instructions captured into IF/ID since reset.

Function
REQ-014 The unit SHALL implement a two-state FSM: BOOT, RUN.
REQ-015 In BOOT the unit SHALL hold PC, leave IF/ID unchanged with if_valid=0, and go to RUN next cycle unconditionally.
REQ-016 In RUN with no stall and no redirect, the unit SHALL load if_instr<=imem_instr, if_pc4<=PC+4, if_valid<=1, PC<=PC+4, and increment fetch_count.
REQ-017 In RUN with stall=1 and redirect=0, the unit SHALL hold PC, if_instr, if_pc4, if_valid and fetch_count.
REQ-018 In RUN with redirect=1, the unit SHALL load PC<={redirect_pc[31:2],2'b00}, set if_valid<=0 (flush), leave if_instr/if_pc4 unchanged, and not increment fetch_count.
REQ-019 redirect SHALL take priority over stall; rst SHALL take priority over both.
REQ-020 If redirect=1 and redirect_pc[1:0]!=0, misalign SHALL set to 1 and stay set until rst.
REQ-021 redirect in BOOT SHALL be ignored.
REQ-022 PC and fetch_count arithmetic SHALL be unsigned 32-bit modulo 2^32; PC 32'hFFFF_FFFC+4 wraps to 0, if_pc4 likewise.
REQ-023 Fetch latency SHALL be one cycle: the word at imem_addr in cycle N appears on if_instr in cycle N+1.
REQ-024 imem_addr SHALL be driven directly from the PC register, with no combinational path from any input.

Reset
REQ-025 While rst=1 at posedge clk: state<=BOOT, PC<=RESET_PC, if_instr<=32'h0 (NOP), if_pc4<=0, if_valid<=0, misalign<=0, fetch_count<=0.
REQ-026 rst asserted mid-operation (including during stall or redirect) SHALL discard all in-flight state identically to REQ-025.

Structure
REQ-027 Shared package cpu_defs SHALL hold RESET_PC default, NOP encoding 32'h0, and the FSM state encoding (BOOT=1'b0, RUN=1'b1).
REQ-028 The IF/ID register (if_instr, if_pc4, if_valid with load/flush/hold controls) SHALL be a sub-module named if_id_reg; PC, FSM, counter and flag stay in fetch_unit.

Verification
REQ-029 Reset then 4 free cycles, imem returns addr|0xA000 -> cycle1 BOOT if_valid=0; cycles2-4 if_instr=0xA000,0xA004,0xA008, if_pc4=4,8,12, fetch_count=3.
REQ-030 stall=1 for 2 cycles at PC=8 -> imem_addr stays 8, if_instr/fetch_count unchanged; release -> PC=12 next cycle.
REQ-031 redirect=1 with redirect_pc=0x40 and stall=1 same cycle -> next cycle imem_addr=0x40, if_valid=0, fetch_count unchanged; following cycle if_pc4=0x44.
REQ-032 redirect_pc=0x43 -> imem_addr=0x40, misalign=1, stays 1 through later redirects; rst clears it.
REQ-033 redirect to 0xFFFF_FFFC, run 2 cycles -> if_pc4=0x0000_0000, imem_addr=0x4.
REQ-034 rst pulsed during stall at PC=0x20 -> next cycle PC=RESET_PC, if_valid=0, if_instr=0, fetch_count=0, state BOOT.
